// File: rtl/mix_columns_iter_if.sv
// Handshake bundle between the round controller and the MixColumns engine.
// Input side:  i_valid/o_ready carry i_data and i_inv into the engine.
// Output side: o_valid/i_ready carry o_data out of the engine.
interface mix_columns_iter_if;
  logic         i_valid;
  logic         o_ready;
  logic [127:0] i_data;
  logic         i_inv;
  logic         o_valid;
  logic         i_ready;
  logic [127:0] o_data;

  // Round controller / testbench side.
  modport master (
    output i_valid, i_data, i_inv, i_ready,
    input  o_ready, o_valid, o_data
  );

  // Engine side.
  modport slave (
    input  i_valid, i_data, i_inv, i_ready,
    output o_ready, o_valid, o_data
  );
endinterface

// File: rtl/mix_columns_iter.sv
// Iterative AES MixColumns: one column per clock through four byte mixers, state mixed in place.
// Latency: result valid 4 cycles after the accept edge; 6 cycles per state with i_ready tied high.
// Backpressure: o_ready only in IDLE; DONE (o_valid, o_data) is held until i_ready.
// Ports: clk, n_rst (async active-low), bus (mix_columns_iter_if.slave: i_valid/o_ready/i_data/i_inv
//        on the input side, o_valid/i_ready/o_data on the output side).
// Optional macro MIX_COLUMNS_INV_EN: when defined, i_inv selects inverse MixColumns per state;
// otherwise the engine is forward-only and i_inv is ignored.
module mix_columns_iter (
  input  logic               clk,
  input  logic               n_rst,
  mix_columns_iter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t       state;
  state_t       state_nxt;
  logic [127:0] st;
  logic [1:0]   col_cnt;
  logic         mode;
  logic         accept;
  logic [31:0]  col;
  logic [7:0]   res [4];

  assign accept = (state == IDLE) && bus.i_valid;

  // FSM state register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.i_valid)       state_nxt = CALC;
      CALC:    if (col_cnt == 2'd3)   state_nxt = DONE;
      DONE:    if (bus.i_ready)       state_nxt = IDLE;
      default:                        state_nxt = IDLE;
    endcase
  end

  // FSM outputs; o_data is the state register itself, meaningful only in DONE
  always_comb begin
    bus.o_ready = (state == IDLE);
    bus.o_valid = (state == DONE);
    bus.o_data  = st;
  end

  // Column col_cnt of the row-major state: byte (r,c) sits at [127-32r-8c -: 8]
  always_comb begin
    col = {st[127 - 8*int'(col_cnt) -: 8],
           st[95  - 8*int'(col_cnt) -: 8],
           st[63  - 8*int'(col_cnt) -: 8],
           st[31  - 8*int'(col_cnt) -: 8]};
  end

  for (genvar r = 0; r < 4; r++) begin : g_row
    mix_columns_byte #(.ROW(r)) u_byte (
      .col (col),
      .inv (mode),
      .res (res[r])
    );
  end

  // State register and column counter; only touched on accept or while mixing
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      st      <= '0;
      col_cnt <= 2'd0;
    end else if (accept) begin
      st      <= bus.i_data;
      col_cnt <= 2'd0;
    end else if (state == CALC) begin
      for (int r = 0; r < 4; r++) begin
        st[127 - 32*r - 8*int'(col_cnt) -: 8] <= res[r];
      end
      col_cnt <= col_cnt + 2'd1;
    end
  end

`ifdef MIX_COLUMNS_INV_EN
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)      mode <= 1'b0;
    else if (accept) mode <= bus.i_inv;
  end
`else
  // Forward-only build: inverse path folds away as the select is constant.
  logic unused_inv;
  assign mode       = 1'b0;
  assign unused_inv = bus.i_inv;
`endif

endmodule

// One output byte of a MixColumns column. ROW rotates the coefficient row:
// forward {2,3,1,1}, inverse {E,B,D,9}, applied to bytes ROW, ROW+1, ROW+2, ROW+3 (mod 4).
// Purely combinational; col is {a0,a1,a2,a3} with a0 in the top byte.
module mix_columns_byte #(
  parameter int ROW = 0
) (
  input  logic [31:0] col,
  input  logic        inv,
  output logic [7:0]  res
);

  // Multiply by x in GF(2^8) modulo 0x11B
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  logic [7:0] b0, b1, b2, b3;
  logic [7:0] fwd, bwd;

  assign b0 = col[31 - 8*(ROW % 4)       -: 8];
  assign b1 = col[31 - 8*((ROW + 1) % 4) -: 8];
  assign b2 = col[31 - 8*((ROW + 2) % 4) -: 8];
  assign b3 = col[31 - 8*((ROW + 3) % 4) -: 8];

  assign fwd = xt(b0) ^ (xt(b1) ^ b1) ^ b2 ^ b3;

  // E = 8^4^2, B = 8^2^1, D = 8^4^1, 9 = 8^1
  assign bwd = (xt(xt(xt(b0))) ^ xt(xt(b0)) ^ xt(b0))
             ^ (xt(xt(xt(b1))) ^ xt(b1) ^ b1)
             ^ (xt(xt(xt(b2))) ^ xt(xt(b2)) ^ b2)
             ^ (xt(xt(xt(b3))) ^ b3);

  assign res = inv ? bwd : fwd;

endmodule
